// File: rtl/ahb_sram_arbiter.sv
// ahb_sram_arbiter: round-robin two-master AHB-Lite arbiter sharing one SRAM slave port
module ahb_sram_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          HRESETn,
  input  logic [1:0]    M0_HTRANS,
  input  logic [AW-1:0] M0_HADDR,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [31:0]   M0_HWDATA,
  output logic          M0_HREADYOUT,
  output logic [31:0]   M0_HRDATA,
  input  logic [1:0]    M1_HTRANS,
  input  logic [AW-1:0] M1_HADDR,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [31:0]   M1_HWDATA,
  output logic          M1_HREADYOUT,
  output logic [31:0]   M1_HRDATA,
  output logic [1:0]    S_HTRANS,
  output logic [AW-1:0] S_HADDR,
  output logic          S_HWRITE,
  output logic [2:0]    S_HSIZE,
  output logic [31:0]   S_HWDATA,
  input  logic          S_HREADY,
  input  logic [31:0]   S_HRDATA
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic [1:0] pend, cap, rdy;
  logic gnt, gnt_n, last, done;
  logic [1:0][AW-1:0] haddr;
  logic [1:0][2:0] hsize;
  logic [1:0] hwrite;
  logic unused_htrans0;
  assign unused_htrans0 = M0_HTRANS[0] ^ M1_HTRANS[0];
  assign done = state == DATA && S_HREADY;
  assign rdy[0] = !pend[0] || (done && !gnt);
  assign rdy[1] = !pend[1] || (done && gnt);
  assign cap = {M1_HTRANS[1] & rdy[1], M0_HTRANS[1] & rdy[0]};
  assign M0_HREADYOUT = rdy[0];
  assign M1_HREADYOUT = rdy[1];
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign S_HTRANS = state == ADDR ? 2'b10 : 2'b00;
  assign S_HADDR = state == ADDR ? haddr[gnt] : '0;
  assign S_HWRITE = state == ADDR && hwrite[gnt];
  assign S_HSIZE = state == ADDR ? hsize[gnt] : 3'd0;
  assign S_HWDATA = gnt ? M1_HWDATA : M0_HWDATA;
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    if (state == IDLE && pend != 2'b00) begin
      state_n = ADDR;
      gnt_n = &pend ? !last : pend[1];
    end else if (state == ADDR) begin
      state_n = DATA;
    end else if (done) begin
      state_n = pend[!gnt] ? ADDR : IDLE;
      gnt_n = pend[!gnt] ? !gnt : gnt;
    end
  end
  // a capture at the completion edge re-arms pend: the set wins over the clear
  always_ff @(posedge clk or posedge HRESETn)
    if (HRESETn) begin
      state <= IDLE;
      pend <= 2'b00;
      gnt <= 1'b0;
      last <= 1'b1;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      if (done) last <= gnt;
      pend <= (pend & ~({gnt, !gnt} & {2{done}})) | cap;
    end
  always_ff @(posedge clk or posedge HRESETn)
    if (HRESETn) begin
      haddr <= '0;
      hsize <= '0;
      hwrite <= 2'b00;
    end else begin
      if (cap[0]) begin
        haddr[0] <= M0_HADDR;
        hwrite[0] <= M0_HWRITE;
        hsize[0] <= M0_HSIZE;
      end
      if (cap[1]) begin
        haddr[1] <= M1_HADDR;
        hwrite[1] <= M1_HWRITE;
        hsize[1] <= M1_HSIZE;
      end
    end
endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// tb_ahb_sram_arbiter: random and directed traffic from two masters into a behavioural SRAM slave,
// checked against a transaction-level model of arbitration order, latency, fairness and memory contents.
module tb_ahb_sram_arbiter;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic HRESETn = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] M0_HTRANS, M1_HTRANS, S_HTRANS;
  logic [AW-1:0] M0_HADDR, M1_HADDR, S_HADDR;
  logic M0_HWRITE, M1_HWRITE, S_HWRITE, M0_HREADYOUT, M1_HREADYOUT, S_HREADY;
  logic [2:0] M0_HSIZE, M1_HSIZE, S_HSIZE;
  logic [31:0] M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA, S_HWDATA, S_HRDATA;

  ahb_sram_arbiter #(.AW(AW)) dut (
    .clk(clk), .HRESETn(HRESETn),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADYOUT(M0_HREADYOUT), .M0_HRDATA(M0_HRDATA),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADYOUT(M1_HREADYOUT), .M1_HRDATA(M1_HRDATA),
    .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA)
  );

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [1:0] a, logic [2:0] sz);
    logic [3:0] be;
    be = sz == 3'd0 ? 4'b0001 << a : sz == 3'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  // SRAM slave with a programmable number of wait states per transfer
  logic [31:0] mem [64];
  logic sdp, sw;
  logic [7:0] sa;
  logic [2:0] ssz;
  int swc;
  int wait_lo = 0, wait_hi = 0;
  bit wipe = 1'b1;
  always @(posedge clk or posedge HRESETn)
    if (HRESETn) begin
      sdp <= 1'b0;
      swc <= 0;
      if (wipe) for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (sdp && swc != 0) begin
      swc <= swc - 1;
    end else begin
      if (sdp && sw) mem[sa[7:2]] <= merge(mem[sa[7:2]], S_HWDATA, sa[1:0], ssz);
      sdp <= S_HTRANS[1];
      if (S_HTRANS[1]) begin
        sa <= S_HADDR[7:0];
        sw <= S_HWRITE;
        ssz <= S_HSIZE;
        swc <= int'($urandom_range(wait_hi, wait_lo));
      end
    end
  assign S_HREADY = !(sdp && swc != 0);
  assign S_HRDATA = sdp ? mem[sa[7:2]] : 32'h0;

  typedef struct {
    bit m;
    logic w;
    logic [AW-1:0] a;
    logic [2:0] sz;
    logic [31:0] d;
    int ew;
  } op_t;

  op_t q0[$], q1[$], svc[$];
  op_t aop[2], dop[2];
  bit av[2], dv[2];
  int dcap[2], fc[2], gap[2];
  int gap_max = 0, cyc = 0;
  bit last_m = 1'b1;
  logic [31:0] sh [64];
  int checks = 0, errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic op_t mk(bit m, logic w, logic [AW-1:0] a, logic [2:0] sz, logic [31:0] d, int ew);
    op_t o;
    o.m = m; o.w = w; o.a = a; o.sz = sz; o.d = d; o.ew = ew;
    return o;
  endfunction

  function automatic op_t rnd_op(bit m);
    logic [2:0] sz;
    logic [7:0] a;
    sz = 3'($urandom_range(2, 0));
    a = 8'($urandom_range(255, 0));
    if (sz == 3'd1) a[0] = 1'b0;
    else if (sz == 3'd2) a[1:0] = 2'b00;
    return mk(m, 1'($urandom_range(1, 0)), {24'h0, a}, sz, $urandom, -1);
  endfunction

  function automatic logic rdy(int m);
    return m == 1 ? M1_HREADYOUT : M0_HREADYOUT;
  endfunction

  task automatic drive();
    M0_HTRANS = av[0] ? 2'b10 : {1'b0, 1'($urandom_range(1, 0))};
    M0_HADDR = av[0] ? aop[0].a : $urandom;
    M0_HWRITE = av[0] ? aop[0].w : 1'($urandom_range(1, 0));
    M0_HSIZE = av[0] ? aop[0].sz : 3'($urandom_range(7, 0));
    M0_HWDATA = dv[0] ? dop[0].d : $urandom;
    M1_HTRANS = av[1] ? 2'b10 : {1'b0, 1'($urandom_range(1, 0))};
    M1_HADDR = av[1] ? aop[1].a : $urandom;
    M1_HWRITE = av[1] ? aop[1].w : 1'($urandom_range(1, 0));
    M1_HSIZE = av[1] ? aop[1].sz : 3'($urandom_range(7, 0));
    M1_HWDATA = dv[1] ? dop[1].d : $urandom;
  endtask

  // requests are served in capture order; a same-edge tie goes to the master not served last
  task automatic push(bit m);
    svc.push_back(aop[m]);
    last_m = m;
    fc[m] = 0;
    dcap[m] = cyc;
  endtask

  task automatic step();
    bit acc[2];
    bit f;
    int exp_m;
    @(negedge clk);
    cyc++;
    for (int m = 0; m < 2; m++) if (dv[m] && rdy(m)) begin
      dv[m] = 1'b0;
      exp_m = svc.size() != 0 ? int'(svc[0].m) : 2;
      check("order", m, exp_m);
      if (svc.size() != 0) void'(svc.pop_front());
      if (dop[m].ew >= 0) check("wait", cyc - dcap[m] - 1, dop[m].ew);
      check("fair", 32'(fc[m] > 1), 0);
      fc[1-m]++;
      if (dop[m].w) sh[dop[m].a[7:2]] = merge(sh[dop[m].a[7:2]], dop[m].d, dop[m].a[1:0], dop[m].sz);
      else check("rdata", m == 1 ? M1_HRDATA : M0_HRDATA, sh[dop[m].a[7:2]]);
    end
    if (S_HTRANS[1] && svc.size() != 0) begin
      check("s_haddr", S_HADDR, svc[0].a);
      check("s_hwrite", 32'(S_HWRITE), 32'(svc[0].w));
      check("s_hsize", 32'(S_HSIZE), 32'(svc[0].sz));
    end else if (S_HTRANS[1]) begin
      check("s_htrans", 32'(S_HTRANS), 0);
    end
    for (int m = 0; m < 2; m++) acc[m] = av[m] && rdy(m);
    if (acc[0] && acc[1]) begin
      f = !last_m;
      push(f);
      push(!f);
    end else if (acc[0]) push(1'b0);
    else if (acc[1]) push(1'b1);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) if (acc[m]) begin
      dv[m] = 1'b1;
      dop[m] = aop[m];
      av[m] = 1'b0;
    end
    for (int m = 0; m < 2; m++) if (!av[m]) begin
      if (gap[m] > 0) gap[m]--;
      else if (m == 0 && q0.size() != 0) begin
        aop[0] = q0.pop_front(); av[0] = 1'b1; gap[0] = int'($urandom_range(gap_max, 0));
      end else if (m == 1 && q1.size() != 0) begin
        aop[1] = q1.pop_front(); av[1] = 1'b1; gap[1] = int'($urandom_range(gap_max, 0));
      end
    end
    drive();
  endtask

  task automatic run(int limit);
    int n;
    bit busy;
    n = 0;
    do begin
      step();
      n++;
      busy = q0.size() != 0 || q1.size() != 0 || av[0] || av[1] || dv[0] || dv[1];
    end while (busy && n < limit);
    check("timeout", 32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sh[i] = '0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_htrans", 32'(S_HTRANS), 0);
    check("rst_s_haddr", S_HADDR, 0);
    check("rst_s_hwrite", 32'(S_HWRITE), 0);
    check("rst_s_hsize", 32'(S_HSIZE), 0);
    check("rst_rdy0", 32'(M0_HREADYOUT), 1);
    check("rst_rdy1", 32'(M1_HREADYOUT), 1);
    @(posedge clk);
    #1;
    HRESETn = 1'b0;
    wipe = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_s_htrans", 32'(S_HTRANS), 0);
      check("idle_rdy0", 32'(M0_HREADYOUT), 1);
      check("idle_rdy1", 32'(M1_HREADYOUT), 1);
    end
    q0.push_back(mk(1'b0, 1'b1, 32'h10, 3'd2, 32'hAAAA5555, 2));
    q1.push_back(mk(1'b1, 1'b1, 32'h20, 3'd2, 32'h1234ABCD, 4));
    run(50);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 1'b0, 32'(32'h40 + 4 * i), 3'd2, 32'h0, i == 0 ? 2 : -1));
      q1.push_back(mk(1'b1, 1'b0, 32'(32'h80 + 4 * i), 3'd2, 32'h0, i == 0 ? 4 : -1));
    end
    run(100);
    q0.push_back(mk(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, 2));
    q1.push_back(mk(1'b1, 1'b0, 32'h20, 3'd2, 32'h0, 4));
    run(50);
    q0.push_back(mk(1'b0, 1'b1, 32'h0, 3'd2, 32'h44332211, 2));
    q0.push_back(mk(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 2));
    run(50);
    q1.push_back(mk(1'b1, 1'b1, 32'h3, 3'd0, 32'hEF000000, 2));
    run(50);
    q0.push_back(mk(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 2));
    run(50);
    // hold the slave in a long data phase, then reset with M1 still queued
    wait_lo = 20;
    wait_hi = 20;
    q0.push_back(mk(1'b0, 1'b0, 32'h4, 3'd2, 32'h0, -1));
    q1.push_back(mk(1'b1, 1'b0, 32'h8, 3'd2, 32'h0, -1));
    repeat (5) step();
    HRESETn = 1'b1;
    #1;
    check("midrst_s_htrans", 32'(S_HTRANS), 0);
    check("midrst_rdy0", 32'(M0_HREADYOUT), 1);
    check("midrst_rdy1", 32'(M1_HREADYOUT), 1);
    av = '{default: 1'b0};
    dv = '{default: 1'b0};
    q0.delete();
    q1.delete();
    svc.delete();
    last_m = 1'b1;
    wait_lo = 0;
    wait_hi = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    HRESETn = 1'b0;
    q0.push_back(mk(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 2));
    run(50);
    gap_max = 3;
    wait_hi = 2;
    for (int i = 0; i < 30; i++) begin
      q0.push_back(rnd_op(1'b0));
      q1.push_back(rnd_op(1'b1));
    end
    run(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
